// File: rtl/nor_truth_sequencer.sv
// rtl/nor_truth_sequencer.sv - exhaustive 4-vector truth-table checker for an external 2-input NOR
module nor_truth_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] y_log
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] idx, idx_n;
  logic       a_n, b_n, busy_n, done_n, pass_n;
  logic [2:0] err_n;
  logic [3:0] log_n;
  logic       mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx     <= 2'd0;
      a_out   <= 1'b0;
      b_out   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= 3'd0;
      y_log   <= 4'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      a_out   <= a_n;
      b_out   <= b_n;
      busy    <= busy_n;
      done    <= done_n;
      pass    <= pass_n;
      err_cnt <= err_n;
      y_log   <= log_n;
    end
  end

  // Outputs are computed one cycle ahead so that every port comes from a flop.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    a_n      = 1'b0;
    b_n      = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    pass_n   = pass;
    err_n    = err_cnt;
    log_n    = y_log;
    mismatch = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETTLE;
          cnt_n   = 4'd0;
          idx_n   = 2'd0;
          busy_n  = 1'b1;
          pass_n  = 1'b0;
          err_n   = 3'd0;
          log_n   = 4'd0;
        end
      end
      SETTLE: begin
        busy_n = 1'b1;
        a_n    = idx[1];
        b_n    = idx[0];
        if (cnt == SETTLE_LAST) begin
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      SAMPLE: begin
        mismatch   = (y_in != ~(a_out | b_out));
        err_n      = err_cnt + {2'b00, mismatch};
        log_n[idx] = y_in;
        cnt_n      = 4'd0;
        if (idx != 2'd3) begin
          idx_n   = idx + 2'd1;
          state_n = SETTLE;
          busy_n  = 1'b1;
          a_n     = idx_n[1];
          b_n     = idx_n[0];
        end else begin
          idx_n   = 2'd0;
          state_n = DONE;
          done_n  = 1'b1;
          pass_n  = (err_n == 3'd0);
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = 2'd0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nor_truth_sequencer.sv
// tb/tb_nor_truth_sequencer.sv - bench for nor_truth_sequencer (SETTLE_CYCLES 2 and 1 instances)
module tb_nor_truth_sequencer;

  localparam int SC [2] = '{2, 1};

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      start;
  logic [1:0]      y;
  logic [1:0]      a, b, busy, done, pass;
  logic [1:0][2:0] err;
  logic [1:0][3:0] ylog;
  int              mode [2];
  bit              check_en = 1'b0;
  int              n_tests = 0;
  int              n_fail = 0;

  always #5 clk = ~clk;

  // mode 0: good NOR, 1: stuck-at-0, 2: gate is actually an OR
  function automatic logic yf(int md, logic aa, logic bb);
    case (md)
      0:       return ~(aa | bb);
      1:       return 1'b0;
      default: return aa | bb;
    endcase
  endfunction

  function automatic logic yv(int md, int v);
    return yf(md, v[1], v[0]);
  endfunction

  assign y[0] = yf(mode[0], a[0], b[0]);
  assign y[1] = yf(mode[1], a[1], b[1]);

  nor_truth_sequencer #(.SETTLE_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .y_in(y[0]),
    .a_out(a[0]), .b_out(b[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_cnt(err[0]), .y_log(ylog[0])
  );

  nor_truth_sequencer #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .y_in(y[1]),
    .a_out(a[1]), .b_out(b[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_cnt(err[1]), .y_log(ylog[1])
  );

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Model: mk = cycle number since the accepting edge (0 = no run); done lands on cycle 4*(S+1)+1.
  int       mk   [2] = '{0, 0};
  logic [3:0] mlog [2] = '{4'd0, 4'd0};
  int       merr [2] = '{0, 0};
  logic     mpass[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s1, last, v, mm;
      s1   = SC[i] + 1;
      last = 4 * s1 + 1;
      if (rst) begin
        mk[i] <= 0; mlog[i] <= 4'd0; merr[i] <= 0; mpass[i] <= 1'b0;
      end else if (mk[i] == 0) begin
        if (start[i]) begin
          mk[i] <= 1; mlog[i] <= 4'd0; merr[i] <= 0; mpass[i] <= 1'b0;
        end
      end else if (mk[i] == last) begin
        mk[i] <= 0;
      end else begin
        mk[i] <= mk[i] + 1;
        if (mk[i] % s1 == 0) begin
          v  = mk[i] / s1 - 1;
          mm = (yv(mode[i], v) != (v == 0)) ? 1 : 0;
          mlog[i][v] <= yv(mode[i], v);
          merr[i]    <= merr[i] + mm;
          if (v == 3) mpass[i] <= (merr[i] + mm == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        int s1, last, k, v, ea, eb, ebusy, edone;
        s1 = SC[i] + 1; last = 4 * s1 + 1; k = mk[i];
        ea = 0; eb = 0; ebusy = 0; edone = 0;
        if (k >= 1 && k < last) begin
          v = (k - 1) / s1;
          ea = v / 2; eb = v % 2; ebusy = 1;
        end
        if (k == last) edone = 1;
        chk($sformatf("u%0d_a_out", i), a[i], ea);
        chk($sformatf("u%0d_b_out", i), b[i], eb);
        chk($sformatf("u%0d_busy", i), busy[i], ebusy);
        chk($sformatf("u%0d_done", i), done[i], edone);
        chk($sformatf("u%0d_pass", i), pass[i], mpass[i]);
        chk($sformatf("u%0d_err_cnt", i), err[i], merr[i]);
        chk($sformatf("u%0d_y_log", i), ylog[i], mlog[i]);
      end
    end
  end

  task automatic run(int i, int md, logic [3:0] el, int ee, logic ep, int ec, string nm);
    int c;
    mode[i] = md;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    c = 1;
    while (!done[i] && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_done_cycle"}, c, ec);
    chk({nm, "_y_log"}, ylog[i], el);
    chk({nm, "_err_cnt"}, err[i], ee);
    chk({nm, "_pass"}, pass[i], ep);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, nd;
    int seq [$];
    rst = 1'b1; start = 2'b00; mode[0] = 0; mode[1] = 0;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_y_log", ylog[0], 0);
    chk("reset_pass", pass, 0);
    rst = 1'b0;
    @(negedge clk);

    run(0, 0, 4'b0001, 0, 1'b1, 13, "nor_s2");
    run(0, 1, 4'b0000, 1, 1'b0, 13, "stuck0_s2");
    run(0, 2, 4'b1110, 4, 1'b0, 13, "or_s2");
    run(1, 0, 4'b0001, 0, 1'b1, 9,  "nor_s1");
    run(1, 2, 4'b1110, 4, 1'b0, 9,  "or_s1");
    chk("hold_after_done_u0", ylog[0], 4'b1110);

    // start held high: runs restart only from IDLE, every 14 cycles
    mode[0] = 0;
    start[0] = 1'b1;
    nd = 0;
    for (int n = 1; n <= 42; n++) begin
      @(negedge clk);
      if (done[0]) nd++;
      if (n <= 12) seq.push_back(a[0] * 2 + b[0]);
    end
    start[0] = 1'b0;
    chk("held_start_done_count", nd, 3);
    for (int n = 0; n < 12; n++) chk($sformatf("held_start_vec%0d", n), seq[n], n / 3);
    repeat (20) @(negedge clk);

    // reset during vector 2 settle
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    c = 0;
    while (!(a[0] && !b[0]) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("rst_reached_vec2", (a[0] && !b[0]) ? 1 : 0, 1);
    chk("rst_vec2_in_settle", c, 6);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort_a", a[0], 0);
    chk("rst_abort_b", b[0], 0);
    chk("rst_abort_busy", busy[0], 0);
    chk("rst_abort_done", done[0], 0);
    chk("rst_abort_err", err[0], 0);
    chk("rst_abort_y_log", ylog[0], 0);
    rst = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    chk("rst_no_done", nd, 0);

    // start accepted on the first edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("start_after_rst_busy", busy[0], 1);
    repeat (16) @(negedge clk);
    chk("start_after_rst_pass", pass[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_truth_sequencer.md
NOR_TRUTH_SEQUENCER -- requirements
Module: nor_truth_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, cycles a vector is held before sampling (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request one full 4-vector run; sampled on rising edge.
REQ-005 SHALL have port y_in  input  1  output of the downstream 2-input NOR under test.
REQ-006 SHALL have port a_out  output  1  drives NOR input a.
REQ-007 SHALL have port b_out  output  1  drives NOR input b.
REQ-008 SHALL have port busy  output  1  high while a run is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse at end of run.
REQ-010 SHALL have port pass  output  1  run result; high iff err_cnt is 0 at end of run.
REQ-011 SHALL have port err_cnt  output  3  number of mismatching vectors in current/last run (0..4).
REQ-012 SHALL have port y_log  output  4  captured y_in per vector; bit i holds vector i.

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-014 SHALL, in IDLE with start=1 at an edge, enter SETTLE with vector index 0 and clear err_cnt, y_log, pass.
REQ-015 SHALL ignore start in every state other than IDLE.
REQ-016 SHALL apply vectors in order 0..3, with a_out = index[1] and b_out = index[0] (00, 01, 10, 11).
REQ-017 SHALL hold a_out/b_out stable through SETTLE and SAMPLE of a vector.
REQ-018 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, then enter SAMPLE for exactly one cycle.
REQ-019 SHALL, at the edge ending SAMPLE, write y_in into y_log[index] and increment err_cnt if y_in != NOR(a_out, b_out).
REQ-020 SHALL, after SAMPLE, advance index and return to SETTLE if index < 3, else enter DONE.
REQ-021 SHALL hold DONE one cycle: done=1, pass=(err_cnt==0), then return to IDLE.
REQ-022 SHALL make each vector occupy SETTLE_CYCLES+1 cycles; done is high in cycle 4*(SETTLE_CYCLES+1)+1 after the accepting edge.
REQ-023 SHALL drive busy=1 in SETTLE and SAMPLE, 0 in IDLE and DONE.
REQ-024 SHALL drive a_out=b_out=0 in IDLE and DONE.
REQ-025 SHALL hold err_cnt, y_log, pass unchanged after DONE until the next accepted start.
REQ-026 SHALL never wrap err_cnt (maximum 4 fits 3 bits).

Reset
REQ-027 SHALL, on rst=1 at an edge, enter IDLE with a_out=0, b_out=0, busy=0, done=0, pass=0, err_cnt=0, y_log=0, index=0.
REQ-028 SHALL give rst priority over start and over any in-progress run; aborted run produces no done pulse.
REQ-029 SHALL accept start on the first edge after rst deasserts.

Verification
REQ-030 SHALL cover: correct NOR, SETTLE_CYCLES=2, one-cycle start -> done in cycle 13 after accepting edge, y_log=4'b0001, err_cnt=0, pass=1.
REQ-031 SHALL cover: y_in stuck at 0 -> y_log=4'b0000, err_cnt=1, pass=0.
REQ-032 SHALL cover: DUT replaced by OR -> y_log=4'b1110, err_cnt=4, pass=0.
REQ-033 SHALL cover: start held high continuously -> starts during busy ignored; a new run is accepted only in IDLE after each DONE cycle; a_out/b_out sequence 00,01,10,11 repeats.
REQ-034 SHALL cover: rst asserted while vector 2 (a=1,b=0) is in SETTLE -> next cycle all outputs at reset values, no done pulse.
REQ-035 SHALL cover: SETTLE_CYCLES=1 -> each vector held 2 cycles, done in cycle 9 after accepting edge.
